// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg -- shared processor constants and the writeback entry type.
//   DATA_W / ADDR_W : register-bank data and address widths
//   R0_ADDR         : address of r0 (not hardwired in the register bank)
//   wb_entry_t      : pending writeback {live, addr, data}
package wb_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] R0_ADDR = '0;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// wb_pend_fifo -- pending mul/div result FIFO for the writeback arbiter.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, push_entry  store an entry (caller guarantees !full)
//   pop             retire the head entry (caller guarantees !empty)
//   kill_en, kill_addr  clear live on every stored entry targeting kill_addr
//   hz_addr, hz_hit combinational hazard query against live entries
//   head            current head entry
//   full, empty, count  occupancy status (live and dead entries)
module wb_pend_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [ADDR_W-1:0]        kill_addr,
    input  logic [ADDR_W-1:0]        hz_addr,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     hz_hit
);

    localparam int unsigned PW = $clog2(DEPTH);

    // Pointers carry one extra bit to tell full from empty.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // Popped slots have live cleared, so a slot outside the occupied window
    // is always dead and the hazard compare needs no occupancy mask.
    always_comb begin
        hz_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem[i].live && (mem[i].addr == hz_addr)) begin
                hz_hit = 1'b1;
            end
        end
        if (hz_addr == R0_ADDR) begin
            hz_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem[i].addr == kill_addr)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr[PW-1:0]].live <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            // The push slot is never an occupied slot, so it cannot collide
            // with the kill or pop updates above.
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter -- sole driver of the register-bank write port. Merges
// single-cycle ALU/load results with buffered mul/div results; writes to r0
// are dropped and stale buffered results are killed by newer ALU writes.
// Optional feature macro: WB_BYPASS_EN (live mul/div result goes straight
// to the write port when the FIFO is empty and the ALU does not win).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   alu_valid/alu_addr/alu_data   ALU/load result (no backpressure)
//   md_valid/md_ready/md_addr/md_data  mul/div result handshake
//   hz_addr, hz_hit               decode hazard query (combinational)
//   stall_req                     registered request for one ALU bubble
//   pend_count                    FIFO occupancy
//   rf_we/rf_waddr/rf_wdata       registered register-bank write port
module wb_arbiter #(
    parameter int unsigned DATA_W     = wb_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W     = wb_arbiter_pkg::ADDR_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [ADDR_W-1:0]        md_addr,
    input  logic [DATA_W-1:0]        md_data,
    input  logic [ADDR_W-1:0]        hz_addr,
    output logic                     hz_hit,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   pend_count,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
);

    import wb_arbiter_pkg::*;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic      alu_win;
    logic      push_live;
    logic      push;
    logic      pop;
    logic      bypass;
    logic      full;
    logic      empty;
    wb_entry_t push_entry;
    wb_entry_t head;
    logic [SW-1:0] starve_cnt;

    assign alu_win   = alu_valid && (alu_addr != R0_ADDR);
    // A same-cycle ALU write to the same register is newer than this result.
    assign push_live = (md_addr != R0_ADDR) && !(alu_valid && (alu_addr == md_addr));
    assign md_ready  = !full;

`ifdef WB_BYPASS_EN
    assign bypass = !alu_win && empty && md_valid && md_ready && push_live;
`else
    assign bypass = 1'b0;
`endif

    assign push       = md_valid && md_ready && !bypass;
    assign pop        = !alu_win && !empty;
    assign push_entry = '{live: push_live, addr: md_addr, data: md_data};

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_win),
        .kill_addr  (alu_addr),
        .hz_addr    (hz_addr),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (pend_count),
        .hz_hit     (hz_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (alu_win) begin
            rf_we    <= 1'b1;
            rf_waddr <= alu_addr;
            rf_wdata <= alu_data;
        end else if (pop) begin
            // A killed entry still consumes its slot, just without a write.
            rf_we    <= head.live;
            rf_waddr <= head.addr;
            rf_wdata <= head.data;
        end else if (bypass) begin
            rf_we    <= 1'b1;
            rf_waddr <= md_addr;
            rf_wdata <= md_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // stall_req follows the registered counter, so it rises one cycle after
    // the counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (alu_win && (starve_cnt < SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            stall_req <= (starve_cnt == SW'(STARVE_MAX));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [4:0]  hz_addr;
    logic        hz_hit;
    logic        stall_req;
    logic [2:0]  pend_count;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .DEPTH      (4),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_addr    (md_addr),
        .md_data    (md_data),
        .hz_addr    (hz_addr),
        .hz_hit     (hz_hit),
        .stall_req  (stall_req),
        .pend_count (pend_count),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        exp_we;
        logic        chk_ad;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every observed register write must match the oldest
    // expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got r%0d=%h expected no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", 32'(rf_waddr), 32'(e.addr));
                check("sb_data", rf_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        md_valid  = mv;
        md_addr   = ma;
        md_data   = md;
        if (av && aa != 5'd0) exp_q.push_back('{aa, ad});
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{a, d});
    endtask

    initial begin
        logic stall_seen;
        total  = 0;
        passed = 0;
        vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{1'b0, 5'd4,  32'h55555555, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 1'b1, 5'd31, 32'hA5A5A5A5};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1, 5'd1,  32'h00000000};

        rst_n   = 1'b0;
        hz_addr = 5'd0;
        idle();
        step();
        step();
        check("rst_we",    32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_pend",  32'(pend_count), 32'd0);
        check("rst_ready", 32'(md_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ALU-only vectors
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, 1'b0, 5'd0, 32'd0);
            step();
            check($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            if (vecs[i].chk_ad) begin
                check($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d_data", i), rf_wdata, vecs[i].exp_data);
            end
        end
        idle();
        step();

        // Mul/div alone
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12);
        expect_wr(5'd5, 32'h12);
        step();
        idle();
`ifdef WB_BYPASS_EN
        check("md_bypass_we",   32'(rf_we), 32'd1);
        check("md_bypass_addr", 32'(rf_waddr), 32'd5);
        check("md_bypass_data", rf_wdata, 32'h12);
        check("md_bypass_pend", 32'(pend_count), 32'd0);
        step();
`else
        check("md_first_we",  32'(rf_we), 32'd0);
        check("md_first_pend", 32'(pend_count), 32'd1);
        step();
        check("md_we",   32'(rf_we), 32'd1);
        check("md_addr", 32'(rf_waddr), 32'd5);
        check("md_data", rf_wdata, 32'h12);
        check("md_pend", 32'(pend_count), 32'd0);
`endif
        step();

        // Full FIFO under continuous ALU traffic, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'hA000 + 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            step();
        end
        check("full_ready", 32'(md_ready), 32'd0);
        check("full_pend",  32'(pend_count), 32'd4);
        check("full_stall_early", 32'(stall_req), 32'd0);
        stall_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (stall_req) begin
                stall_seen = 1'b1;
                break;
            end
            drive(1'b1, 5'd1, 32'hA010 + 32'(k), 1'b0, 5'd0, 32'd0);
            step();
        end
        check("stall_req", 32'(stall_seen), 32'd1);
        check("stall_pend", 32'(pend_count), 32'd4);
        idle();
        for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain%0d_we", i),   32'(rf_we), 32'd1);
            check($sformatf("drain%0d_addr", i), 32'(rf_waddr), 32'(10 + i));
            check($sformatf("drain%0d_data", i), rf_wdata, 32'h100 + 32'(i));
            check($sformatf("drain%0d_pend", i), 32'(pend_count), 32'(3 - i));
        end
        step();
        check("drain_stall_low", 32'(stall_req), 32'd0);
        check("drain_ready", 32'(md_ready), 32'd1);

        // Kill: buffered r7 superseded by a later ALU write
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd7, 32'h1);
        step();
        check("kill_pend", 32'(pend_count), 32'd1);
        drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
        hz_addr = 5'd7;
        #1;
        check("kill_hz_before", 32'(hz_hit), 32'd1);
        step();
        check("kill_alu_data", rf_wdata, 32'h2);
        check("kill_hz_after", 32'(hz_hit), 32'd0);
        idle();
        step();
        check("kill_pop_we",   32'(rf_we), 32'd0);
        check("kill_pop_pend", 32'(pend_count), 32'd0);

        // Same-cycle push and ALU write to r9
        drive(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB);
        step();
        check("same_we",   32'(rf_we), 32'd1);
        check("same_data", rf_wdata, 32'hAAAA);
        check("same_pend", 32'(pend_count), 32'd1);
        idle();
        hz_addr = 5'd9;
        #1;
        check("same_hz", 32'(hz_hit), 32'd0);
        step();
        check("same_pop_we",   32'(rf_we), 32'd0);
        check("same_pop_pend", 32'(pend_count), 32'd0);
        hz_addr = 5'd0;

        // Reset with three pending entries
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1, 32'hC000 + 32'(i), 1'b1, 5'(20 + i), 32'h200 + 32'(i));
            step();
        end
        check("pre_rst_pend", 32'(pend_count), 32'd3);
        hz_addr = 5'd21;
        #1;
        check("pre_rst_hz", 32'(hz_hit), 32'd1);
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(rf_we), 32'd0);
        check("mid_rst_waddr", 32'(rf_waddr), 32'd0);
        check("mid_rst_wdata", rf_wdata, 32'd0);
        check("mid_rst_stall", 32'(stall_req), 32'd0);
        check("mid_rst_pend",  32'(pend_count), 32'd0);
        check("mid_rst_ready", 32'(md_ready), 32'd1);
        check("mid_rst_hz",    32'(hz_hit), 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_rst%0d_we", i), 32'(rf_we), 32'd0);
            check($sformatf("post_rst%0d_pend", i), 32'(pend_count), 32'd0);
        end

        @(negedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
